// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants: funct3 opcodes, mul/div FSM states, XLEN
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide, 32 cycles, drives regfile write port
//
// Ports:
//   iCLK, iRST          clock (rising), asynchronous active-low reset
//   iSTART              request strobe, sampled only while oREADY=1
//   iKILL               synchronous abort (pipeline flush)
//   iFUNCT3             RV32M opcode
//   iRS1_VAL, iRS2_VAL  operands A and B
//   iRD                 destination register index
//   oREADY              high in IDLE
//   oDONE               one-cycle result strobe
//   oRD                 regfile write address, 0 except on the oDONE cycle
//   oRESULT             regfile write data, holds its last value between results
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSTART,
    input  logic            iKILL,
    input  logic [2:0]      iFUNCT3,
    input  logic [XLEN-1:0] iRS1_VAL,
    input  logic [XLEN-1:0] iRS2_VAL,
    input  logic [4:0]      iRD,
    output logic            oREADY,
    output logic            oDONE,
    output logic [4:0]      oRD,
    output logic [XLEN-1:0] oRESULT
);

    state_e              state_q;
    logic [4:0]          cnt_q;
    logic [2:0]          funct3_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     a_q;        // |rs1|: multiplicand, or dividend shifted out MSB first
    logic [XLEN-1:0]     b_q;        // |rs2|: multiplier shifted out LSB first, or divisor
    logic [2*XLEN-1:0]   acc_q;      // mul: {partial high, product low}; div: {remainder, quotient}
    logic                neg_res_q;  // operand signs differ
    logic                neg_rem_q;  // dividend negative
    logic                ready_q, done_q;
    logic [4:0]          ord_q;
    logic [XLEN-1:0]     result_q;

    // Start-side decode
    logic            in_sgn_a, in_sgn_b, rs1_neg, rs2_neg, in_fast;
    logic [XLEN-1:0] rs1_abs, rs2_abs, fast_result;

    always_comb begin
        in_sgn_a = (iFUNCT3 == F3_MULH) || (iFUNCT3 == F3_MULHSU) ||
                   (iFUNCT3 == F3_DIV)  || (iFUNCT3 == F3_REM);
        in_sgn_b = (iFUNCT3 == F3_MULH) || (iFUNCT3 == F3_DIV) || (iFUNCT3 == F3_REM);
        rs1_neg  = in_sgn_a && iRS1_VAL[XLEN-1];
        rs2_neg  = in_sgn_b && iRS2_VAL[XLEN-1];
        rs1_abs  = rs1_neg ? -iRS1_VAL : iRS1_VAL;
        rs2_abs  = rs2_neg ? -iRS2_VAL : iRS2_VAL;
        in_fast     = 1'b0;
        fast_result = '0;
        // funct3[2] selects divide, funct3[1] selects remainder within divide
        if (iFUNCT3[2] && (iRS2_VAL == '0)) begin
            in_fast     = 1'b1;
            fast_result = iFUNCT3[1] ? iRS1_VAL : '1;
        end else if (((iFUNCT3 == F3_DIV) || (iFUNCT3 == F3_REM)) &&
                     (iRS1_VAL == 32'h8000_0000) && (iRS2_VAL == 32'hFFFF_FFFF)) begin
            in_fast     = 1'b1;
            fast_result = iFUNCT3[1] ? '0 : 32'h8000_0000;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_d, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_result;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        // Difference is below the divisor whenever it is kept, so the low word is exact
        div_sub   = div_shift[XLEN-1:0] - b_q;
        if (funct3_q[2])
            acc_d = {div_ge ? div_sub : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
        else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix = neg_res_q ? -acc_d : acc_d;
        quot_fix = neg_res_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        case (funct3_q)
            F3_MUL:                 final_result = prod_fix[XLEN-1:0];
            F3_DIV, F3_DIVU:        final_result = quot_fix;
            F3_REM, F3_REMU:        final_result = rem_fix;
            default:                final_result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            ord_q     <= '0;
            result_q  <= '0;
        end else if (iKILL) begin
            // Flush wins everywhere; an IDLE request in the same cycle is dropped
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ord_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iSTART) begin
                        funct3_q  <= iFUNCT3;
                        rd_q      <= iRD;
                        a_q       <= rs1_abs;
                        b_q       <= rs2_abs;
                        acc_q     <= '0;
                        neg_res_q <= rs1_neg ^ rs2_neg;
                        neg_rem_q <= rs1_neg;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        if (in_fast) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            ord_q    <= iRD;
                            result_q <= fast_result;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (funct3_q[2]) a_q <= {a_q[XLEN-2:0], 1'b0};
                    else             b_q <= {1'b0, b_q[XLEN-1:1]};
                    if (cnt_q == 5'd31) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        ord_q    <= rd_q;
                        result_q <= final_result;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    ord_q   <= '0;
                end
            endcase
        end
    end

    assign oREADY  = ready_q;
    assign oDONE   = done_q;
    assign oRD     = ord_q;
    assign oRESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iSTART = 1'b0;
    logic        iKILL = 1'b0;
    logic [2:0]  iFUNCT3 = '0;
    logic [31:0] iRS1_VAL = '0;
    logic [31:0] iRS2_VAL = '0;
    logic [4:0]  iRD = '0;
    logic        oREADY, oDONE;
    logic [4:0]  oRD;
    logic [31:0] oRESULT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    muldiv_unit dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iKILL(iKILL),
        .iFUNCT3(iFUNCT3), .iRS1_VAL(iRS1_VAL), .iRS2_VAL(iRS2_VAL), .iRD(iRD),
        .oREADY(oREADY), .oDONE(oDONE), .oRD(oRD), .oRESULT(oRESULT)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!oREADY && n < 60) begin
            @(negedge iCLK);
            n++;
        end
        chk("wait_ready", {31'd0, oREADY}, 32'd1);
    endtask

    // Issue one op at a negedge; start edge is the following posedge.
    // lat=1 is the first cycle after the start edge.
    task automatic run_op(input vec_t v);
        int lat;
        int rd_bad = 0;
        wait_ready();
        iFUNCT3 = v.f3; iRS1_VAL = v.a; iRS2_VAL = v.b; iRD = v.rd; iSTART = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        iRS1_VAL = 32'hDEAD_BEEF; iRS2_VAL = 32'h1234_5678;
        lat = 1;
        while (!oDONE && lat < 60) begin
            if (oRD !== 5'd0) rd_bad++;
            @(negedge iCLK);
            lat++;
        end
        chk({v.name, "_lat"}, lat, v.lat);
        chk({v.name, "_res"}, oRESULT, v.exp);
        chk({v.name, "_rd"}, {27'd0, oRD}, {27'd0, v.rd});
        chk({v.name, "_rd0_before"}, rd_bad, 0);
        @(negedge iCLK);
        chk({v.name, "_after"}, {oDONE, oRD, oREADY}, 7'b0_00000_1);
    endtask

    initial begin
        int lat, t1, t2, seen;

        vecs.push_back('{"mul_7x6",      3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         33});
        vecs.push_back('{"mul_m3x5",     3'd0, 32'hFFFF_FFFD,  32'd5,          5'd9,  32'hFFFF_FFF1,  33});
        vecs.push_back('{"mul_rd0",      3'd0, 32'd3,          32'd3,          5'd0,  32'd9,          33});
        vecs.push_back('{"mulh_m1m1",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  33});
        vecs.push_back('{"mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33});
        vecs.push_back('{"mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  33});
        vecs.push_back('{"div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  33});
        vecs.push_back('{"rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33});
        vecs.push_back('{"div_7_m2",     3'd4, 32'd7,          32'hFFFF_FFFE,  5'd7,  32'hFFFF_FFFD,  33});
        vecs.push_back('{"rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE,  5'd8,  32'd1,          33});
        vecs.push_back('{"divu_100_7",   3'd5, 32'd100,        32'd7,          5'd10, 32'd14,         33});
        vecs.push_back('{"remu_100_7",   3'd7, 32'd100,        32'd7,          5'd11, 32'd2,          33});
        vecs.push_back('{"div_5_0",      3'd4, 32'd5,          32'd0,          5'd12, 32'hFFFF_FFFF,  1});
        vecs.push_back('{"rem_5_0",      3'd6, 32'd5,          32'd0,          5'd13, 32'd5,          1});
        vecs.push_back('{"divu_5_0",     3'd5, 32'd5,          32'd0,          5'd14, 32'hFFFF_FFFF,  1});
        vecs.push_back('{"remu_7_0",     3'd7, 32'd7,          32'd0,          5'd15, 32'd7,          1});
        vecs.push_back('{"div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  1});
        vecs.push_back('{"rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          1});

        // Reset state
        #12;
        chk("reset_outputs", {oREADY, oDONE, oRD}, 7'b1_0_00000);
        chk("reset_result", oRESULT, 32'd0);
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);

        foreach (vecs[i]) run_op(vecs[i]);

        // iSTART mid-CALC is ignored: original DIVU result returned
        wait_ready();
        iFUNCT3 = 3'd5; iRS1_VAL = 32'd100; iRS2_VAL = 32'd7; iRD = 5'd20; iSTART = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        lat = 1;
        while (!oDONE && lat < 60) begin
            if (lat == 10) begin
                iSTART = 1'b1; iFUNCT3 = 3'd0; iRS1_VAL = 32'd2; iRS2_VAL = 32'd2; iRD = 5'd21;
            end else begin
                iSTART = 1'b0;
            end
            @(negedge iCLK);
            lat++;
        end
        iSTART = 1'b0;
        chk("ign_start_lat", lat, 33);
        chk("ign_start_res", oRESULT, 32'd14);
        chk("ign_start_rd", {27'd0, oRD}, 32'd20);

        // iKILL in CALC at cycle 20: no oDONE, ready after next edge
        @(negedge iCLK);
        wait_ready();
        iFUNCT3 = 3'd5; iRS1_VAL = 32'd99; iRS2_VAL = 32'd9; iRD = 5'd22; iSTART = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        seen = 0;
        for (int k = 1; k < 20; k++) begin
            if (oDONE) seen++;
            @(negedge iCLK);
        end
        iKILL = 1'b1;
        @(negedge iCLK);
        iKILL = 1'b0;
        chk("kill_ready", {31'd0, oREADY}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (oDONE || oRD != 5'd0) seen++;
            @(negedge iCLK);
        end
        chk("kill_no_done", seen, 0);
        chk("kill_result_held", oRESULT, 32'd14);

        // Reset pulse at cycle 15 of a DIVU
        wait_ready();
        iFUNCT3 = 3'd5; iRS1_VAL = 32'd50; iRS2_VAL = 32'd3; iRD = 5'd23; iSTART = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        for (int k = 1; k < 15; k++) @(negedge iCLK);
        iRST = 1'b0;
        #1;
        chk("rst_mid_outputs", {oREADY, oDONE, oRD}, 7'b1_0_00000);
        chk("rst_mid_result", oRESULT, 32'd0);
        @(negedge iCLK);
        iRST = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (oDONE) seen++;
            @(negedge iCLK);
        end
        chk("rst_mid_no_done", seen, 0);
        chk("rst_mid_ready", {31'd0, oREADY}, 32'd1);

        // Back-to-back MULs with iSTART held high: 34 cycles between strobes
        iFUNCT3 = 3'd0; iRS1_VAL = 32'd3; iRS2_VAL = 32'd4; iRD = 5'd24; iSTART = 1'b1;
        t1 = -1; t2 = -1;
        for (int k = 0; k < 100 && t2 < 0; k++) begin
            @(negedge iCLK);
            if (oDONE) begin
                if (t1 < 0) t1 = cyc;
                else        t2 = cyc;
            end
        end
        iSTART = 1'b0;
        chk("b2b_spacing", t2 - t1, 34);
        chk("b2b_result", oRESULT, 32'd12);
        chk("b2b_rd", {27'd0, oRD}, 32'd24);

        repeat (3) @(negedge iCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
